// File: rtl/feature_fifo_fwft_if.sv
// ---------------------------------------------------------------------------
// feature_fifo_fwft_if
// Handshake bundle for the feature-map FIFO: write side (valid/ready/data/
// last) and read side (valid/ready/data/last).
//   master : the environment (loader pushes words, conv engine pops them)
//   slave  : the FIFO itself
// Word width is N_CH*DATA_W with lane 0 in the LSBs.
// ---------------------------------------------------------------------------
interface feature_fifo_fwft_if #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 1
);
  localparam int WORD_W = N_CH * DATA_W;

  logic              i_wr_valid;
  logic              o_wr_ready;
  logic [WORD_W-1:0] i_wr_data;
  logic              i_wr_last;
  logic              o_rd_valid;
  logic              i_rd_ready;
  logic [WORD_W-1:0] o_rd_data;
  logic              o_rd_last;

  modport master (
    output i_wr_valid, i_wr_data, i_wr_last, i_rd_ready,
    input  o_wr_ready, o_rd_valid, o_rd_data, o_rd_last
  );

  modport slave (
    input  i_wr_valid, i_wr_data, i_wr_last, i_rd_ready,
    output o_wr_ready, o_rd_valid, o_rd_data, o_rd_last
  );
endinterface

// File: rtl/feature_fifo_fwft.sv
// ---------------------------------------------------------------------------
// feature_fifo_fwft
// First-word-fall-through FIFO buffering feature-map pixels between the input
// loader and the conv engine. Each entry is N_CH packed lanes plus a
// frame-last tag. Capacity DEPTH = (DEPTH-1)-word RAM + one output register.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_flush        synchronous clear of contents and flags
//   bus (slave)    write/read handshakes, data and last tag
//   o_count        words held (RAM + output register)
//   o_almost_full  o_count >= AF_THRESH
//   o_overflow     sticky: write attempted while o_wr_ready=0
// ---------------------------------------------------------------------------
module feature_fifo_fwft #(
  parameter int DATA_W    = 8,
  parameter int N_CH      = 1,
  parameter int DEPTH     = 729,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  feature_fifo_fwft_if.slave   bus,
  output logic [CNT_W-1:0]     o_count,
  output logic                 o_almost_full,
  output logic                 o_overflow
);

  localparam int WORD_W = N_CH * DATA_W;
  localparam int RAM_D  = DEPTH - 1;
  localparam int PTR_W  = (RAM_D > 1) ? $clog2(RAM_D) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAM_D - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);

  // RAM entry = {last, data}; read through the output register below.
  logic [WORD_W:0] mem [RAM_D];

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic              wr_ready_reg;
  logic              rd_valid_reg;
  logic              rd_valid_next;
  logic              rd_last_reg;
  logic [WORD_W-1:0] rd_data_reg;
  logic              overflow_reg;

  logic wr_fire;
  logic rd_fire;
  logic ram_has_data;
  logic load_out;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_fire = bus.i_wr_valid && wr_ready_reg && !i_flush;
    rd_fire = rd_valid_reg && bus.i_rd_ready && !i_flush;
    // count includes the output register, so the RAM holds count - rd_valid.
    ram_has_data = count_reg > {{(CNT_W-1){1'b0}}, rd_valid_reg};
    // Refill the output register when it is empty or being consumed.
    load_out = !i_flush && ram_has_data && (!rd_valid_reg || bus.i_rd_ready);

    count_next = count_reg;
    if (wr_fire && !rd_fire) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!wr_fire && rd_fire) begin
      count_next = count_reg - CNT_W'(1);
    end

    rd_valid_next = rd_valid_reg;
    if (load_out) begin
      rd_valid_next = 1'b1;
    end else if (rd_fire) begin
      rd_valid_next = 1'b0;
    end
  end

  // Storage array, no reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg] <= {bus.i_wr_last, bus.i_wr_data};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      wr_ready_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
      rd_data_reg  <= '0;
      overflow_reg <= 1'b0;
    end else if (i_flush) begin
      // Data register intentionally keeps its last value.
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      wr_ready_reg <= 1'b1;
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      // Registered ready: a same-cycle read never frees space for a write.
      wr_ready_reg <= (count_next < CNT_FULL);
      rd_valid_reg <= rd_valid_next;
      if (wr_fire) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (load_out) begin
        rd_ptr_reg                 <= ptr_inc(rd_ptr_reg);
        {rd_last_reg, rd_data_reg} <= mem[rd_ptr_reg];
      end
      if (bus.i_wr_valid && !wr_ready_reg) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign bus.o_wr_ready = wr_ready_reg;
  assign bus.o_rd_valid = rd_valid_reg;
  assign bus.o_rd_data  = rd_data_reg;
  assign bus.o_rd_last  = rd_last_reg;
  assign o_count        = count_reg;
  assign o_almost_full  = (count_reg >= CNT_AF);
  assign o_overflow     = overflow_reg;

endmodule

// File: tb/tb_feature_fifo_fwft.sv
// ---------------------------------------------------------------------------
// tb_feature_fifo_fwft
// Self-checking bench for feature_fifo_fwft (N_CH=3, DATA_W=8, DEPTH=729).
// A queue-based reference model tracks contents; a word becomes visible at
// the head one edge after it was accepted.
// ---------------------------------------------------------------------------
module tb_feature_fifo_fwft;
  localparam int DW    = 8;
  localparam int NC    = 3;
  localparam int DEPTH = 729;
  localparam int AF    = DEPTH - 4;
  localparam int W     = NC * DW;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] count;
  logic          af;
  logic          ovf;

  feature_fifo_fwft_if #(.DATA_W(DW), .N_CH(NC)) bus ();

  feature_fifo_fwft #(.DATA_W(DW), .N_CH(NC), .DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_flush       (flush),
    .bus           (bus),
    .o_count       (count),
    .o_almost_full (af),
    .o_overflow    (ovf)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           t;     // edge number at which the word was accepted
  } ent_t;

  ent_t         mq[$];
  int           ecount;
  bit           m_ready;
  bit           m_valid;
  bit           m_ovf;
  logic [W-1:0] m_data;
  int           total;
  int           bad;

  task automatic model_reset();
    mq.delete();
    m_ready = 1'b0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_data  = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic setin(input bit v, input logic [W-1:0] d, input bit l, input bit r);
    bus.i_wr_valid = v;
    bus.i_wr_data  = d;
    bus.i_wr_last  = l;
    bus.i_rd_ready = r;
  endtask

  // One clock: update the model from the inputs present at the edge.
  task automatic step();
    bit racc;
    @(posedge clk);
    ecount++;
    if (!rst_n) begin
      model_reset();
    end else if (flush) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_ready = 1'b1;
    end else begin
      racc = m_valid && bus.i_rd_ready;
      if (bus.i_wr_valid && !m_ready) m_ovf = 1'b1;
      if (racc) void'(mq.pop_front());
      if (bus.i_wr_valid && m_ready) mq.push_back('{bus.i_wr_data, bus.i_wr_last, ecount});
      m_ready = (mq.size() < DEPTH);
    end
    m_valid = (mq.size() > 0) && (mq[0].t < ecount);
    if (m_valid) m_data = mq[0].data;
    #1;
  endtask

  task automatic mcheck(input string tag);
    chk({tag, ".wr_ready"}, 32'(bus.o_wr_ready), 32'(m_ready));
    chk({tag, ".rd_valid"}, 32'(bus.o_rd_valid), 32'(m_valid));
    chk({tag, ".count"}, 32'(count), mq.size());
    chk({tag, ".almost_full"}, 32'(af), 32'(mq.size() >= AF));
    chk({tag, ".overflow"}, 32'(ovf), 32'(m_ovf));
    chk({tag, ".rd_data"}, 32'(bus.o_rd_data), 32'(m_data));
    if (m_valid) chk({tag, ".rd_last"}, 32'(bus.o_rd_last), 32'(mq[0].last));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit           wv;
    logic [W-1:0] wd;
    bit           wl;
    bit           rr;
    bit           ev;   // expected o_rd_valid after the edge
    logic [W-1:0] ed;   // expected o_rd_data after the edge
    bit           el;   // expected o_rd_last (checked when ev)
    int           ec;   // expected o_count after the edge
  } vec_t;

  vec_t vt[8];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx;
    int nacc;
    logic [W-1:0] d;

    total  = 0;
    bad    = 0;
    ecount = 0;
    model_reset();
    setin(0, '0, 0, 0);

    vt[0] = '{1, 24'h00005A, 0, 0, 0, 24'h000000, 0, 1};
    vt[1] = '{0, 24'h000000, 0, 0, 1, 24'h00005A, 0, 1};
    vt[2] = '{1, 24'h030201, 1, 0, 1, 24'h00005A, 0, 2};
    vt[3] = '{0, 24'h000000, 0, 1, 1, 24'h030201, 1, 1};
    vt[4] = '{1, 24'h0000AA, 0, 1, 0, 24'h030201, 0, 1};
    vt[5] = '{0, 24'h000000, 0, 1, 1, 24'h0000AA, 0, 1};
    vt[6] = '{0, 24'h000000, 0, 1, 0, 24'h0000AA, 0, 0};
    vt[7] = '{0, 24'h000000, 0, 1, 0, 24'h0000AA, 0, 0};

    // ---- post-reset ----
    repeat (3) step();
    mcheck("in_reset");
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst.ready_before_edge", 32'(bus.o_wr_ready), 0);
    step();
    chk("post_rst.ready_after_edge", 32'(bus.o_wr_ready), 1);
    chk("post_rst.count", 32'(count), 0);
    chk("post_rst.valid", 32'(bus.o_rd_valid), 0);
    mcheck("post_rst");

    // ---- table: fall-through, last tag, read/write collisions, empty ----
    for (int i = 0; i < 8; i++) begin
      setin(vt[i].wv, vt[i].wd, vt[i].wl, vt[i].rr);
      step();
      chk($sformatf("vec%0d.valid", i), 32'(bus.o_rd_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d.data", i), 32'(bus.o_rd_data), 32'(vt[i].ed));
      chk($sformatf("vec%0d.count", i), 32'(count), vt[i].ec);
      if (vt[i].ev) chk($sformatf("vec%0d.last", i), 32'(bus.o_rd_last), 32'(vt[i].el));
      mcheck($sformatf("vec%0d", i));
    end

    // ---- frame tag: 5 untagged words, then 0x030201 tagged ----
    for (int k = 0; k < 6; k++) begin
      setin(1, (k < 5) ? 24'h100000 + 24'(k) : 24'h030201, (k == 5), 0);
      step();
      mcheck("tag_wr");
    end
    setin(0, '0, 0, 0);
    step();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("tag%0d.valid", k), 32'(bus.o_rd_valid), 1);
      chk($sformatf("tag%0d.data", k), 32'(bus.o_rd_data),
          (k < 5) ? 32'h100000 + 32'(k) : 32'h030201);
      chk($sformatf("tag%0d.last", k), 32'(bus.o_rd_last), 32'(k == 5));
      setin(0, '0, 0, 1);
      step();
      mcheck("tag_rd");
    end
    chk("tag.empty", 32'(bus.o_rd_valid), 0);

    // ---- fill to full, overflow, drain ----
    for (int i = 0; i < DEPTH; i++) begin
      setin(1, 24'(i % 256), 0, 0);
      step();
      mcheck("fill");
    end
    setin(0, '0, 0, 0);
    step();
    chk("full.count", 32'(count), DEPTH);
    chk("full.wr_ready", 32'(bus.o_wr_ready), 0);
    chk("full.almost_full", 32'(af), 1);
    chk("full.overflow_pre", 32'(ovf), 0);
    setin(1, 24'hEEEEEE, 0, 1);   // full + simultaneous read: write still refused
    step();
    chk("ovf.flag", 32'(ovf), 1);
    chk("ovf.count", 32'(count), DEPTH - 1);
    mcheck("ovf");
    idx = 1;                      // head word 0 was consumed with the refused write
    for (int c = 0; c < 900 && idx < DEPTH; c++) begin
      if (bus.o_rd_valid) begin
        chk("drain.data", 32'(bus.o_rd_data), idx % 256);
        idx++;
      end
      setin(0, '0, 0, 1);
      step();
      mcheck("drain");
    end
    chk("drain.words", idx, DEPTH);
    chk("drain.valid_low", 32'(bus.o_rd_valid), 0);
    chk("drain.overflow_sticky", 32'(ovf), 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush.overflow_clr", 32'(ovf), 0);
    mcheck("flush1");

    // ---- streaming with random read stalls ----
    nacc = 0;
    for (int c = 0; c < 8000 && nacc < 2000; c++) begin
      d = 24'($urandom());
      if (m_ready) nacc++;
      setin(1, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      step();
      mcheck("stream");
    end
    chk("stream.accepted", nacc, 2000);
    for (int c = 0; c < 3000 && mq.size() > 0; c++) begin
      setin(0, '0, 0, 1'($urandom_range(0, 1)));
      step();
      mcheck("stream_drain");
    end
    chk("stream.drained", 32'(count), 0);

    // ---- flush with 10 words held ----
    for (int i = 0; i < 10; i++) begin
      setin(1, 24'hA00000 + 24'(i), 0, 0);
      step();
    end
    setin(0, '0, 0, 0);
    step();
    chk("pre_flush.count", 32'(count), 10);
    setin(1, 24'h777777, 1, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    setin(0, '0, 0, 0);
    chk("flush.count", 32'(count), 0);
    chk("flush.valid", 32'(bus.o_rd_valid), 0);
    chk("flush.overflow", 32'(ovf), 0);
    chk("flush.wr_ready", 32'(bus.o_wr_ready), 1);
    step();
    chk("flush.write_ignored", 32'(count), 0);
    chk("flush.still_empty", 32'(bus.o_rd_valid), 0);
    mcheck("flush2");

    // ---- asynchronous reset mid-stream ----
    for (int i = 0; i < 10; i++) begin
      setin(1, 24'hB00000 + 24'(i), 0, 0);
      step();
    end
    setin(0, '0, 0, 0);
    step();
    chk("pre_rst.valid", 32'(bus.o_rd_valid), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst.valid", 32'(bus.o_rd_valid), 0);
    chk("async_rst.data", 32'(bus.o_rd_data), 0);
    chk("async_rst.count", 32'(count), 0);
    chk("async_rst.wr_ready", 32'(bus.o_wr_ready), 0);
    chk("async_rst.almost_full", 32'(af), 0);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_rel.ready_before_edge", 32'(bus.o_wr_ready), 0);
    step();
    chk("rst_rel.ready_after_edge", 32'(bus.o_wr_ready), 1);
    mcheck("rst_rel");
    setin(1, 24'h123456, 1, 0);
    step();
    setin(0, '0, 0, 0);
    step();
    chk("rst_rel.fall_data", 32'(bus.o_rd_data), 32'h123456);
    mcheck("rst_rel2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/feature_fifo_fwft.md
Name: feature_fifo_fwft

Overview:
- Parametrised first-word-fall-through FIFO that buffers feature-map pixels between the input loader and the conv engine.
- Supports N_CH packed channel lanes, configurable width and depth, and a frame-last tag stored with each word.
- Uses a valid/ready handshake on both sides, with real full/empty tracking, an occupancy count, an almost-full flag and sticky overflow detection.
- The read side is a registered output stage.

Parameters:
- DATA_W, 8, bits per channel lane.
- N_CH, 1, number of channel lanes packed per word (word width = N_CH*DATA_W).
- DEPTH, 729, total word capacity: 27*27 pixels, including the output register.
- AF_THRESH, DEPTH-4, o_almost_full asserts when count >= AF_THRESH.
- CNT_W, $clog2(DEPTH+1), count width (derived; not overridden).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous clear of contents and flags.
- i_wr_valid  in  1  write word present.
- o_wr_ready  out  1  FIFO can accept a word this cycle.
- i_wr_data  in  N_CH*DATA_W  packed lanes; lane 0 in LSBs.
- i_wr_last  in  1  marks last pixel of a feature map.
- o_rd_valid  out  1  head word valid on o_rd_data.
- i_rd_ready  in  1  consumer takes head word.
- o_rd_data  out  N_CH*DATA_W  head word (registered).
- o_rd_last  out  1  last tag of head word.
- o_count  out  CNT_W  words held (RAM + output register).
- o_almost_full  out  1  count >= AF_THRESH.
- o_overflow  out  1  sticky: write attempted while not ready.

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - Outputs: o_rd_valid=0, o_rd_data=0, o_rd_last=0, o_count=0, o_overflow=0, o_almost_full=0, o_wr_ready=0.
  - Internal state: pointers=0.
  - On the first rising edge after deassertion, o_wr_ready goes to 1.
  - Storage contents are not reset.
- Handshakes:
  - A write is accepted on an edge where i_wr_valid && o_wr_ready.
  - A read is consumed on an edge where o_rd_valid && i_rd_ready.
  - o_wr_ready is registered and equals (count < DEPTH). It does not depend on a same-cycle read, so a full FIFO with a simultaneous read still refuses the write.
- Storage and output stage:
  - Storage is a RAM of DEPTH-1 words plus the output register. The RAM is inferable as block RAM with a synchronous read port.
  - The output register refills whenever it is empty or is being consumed and the RAM holds data.
  - Fall-through latency: a word accepted at edge k into an empty FIFO shows o_rd_valid=1 with its data after edge k+1.
  - Back-to-back reads sustain 1 word/clock while data is available.
- Ordering: strict FIFO order. The data and last bit travel together, unchanged.
- Count:
  - count += 1 on an accepted write; count -= 1 on a consumed read; unchanged when both occur on the same edge.
  - count never exceeds DEPTH and never underflows.
- Flags:
  - o_almost_full is combinational from the registered count.
  - o_overflow is set on an edge where i_wr_valid=1 && o_wr_ready=0. The offending word is dropped. The flag stays set until flush or reset.
- Pointers: each wraps from its last RAM index to 0. Full and empty are derived from count, not from pointer equality.
- Flush:
  - On an edge with i_flush=1: pointers=0, count=0, o_rd_valid=0, o_rd_last=0, o_overflow=0, o_wr_ready=1.
  - Any write or read on that same edge is ignored.
- Empty: o_rd_valid=0 and o_rd_data holds its last value. i_rd_ready has no effect.
- Reset mid-operation: all state is discarded immediately. After release, the FIFO starts from the empty state described under Reset.
- Lanes: no arithmetic is performed on lanes. The packing defined at the write port is preserved exactly at the read port.

Test Plan:
- Post-reset: release i_rst_n; o_wr_ready=0 until the first edge, then 1; o_rd_valid=0; o_count=0.
- Fall-through, N_CH=1: write 0x5A alone with i_rd_ready=0. o_rd_valid=1 and o_rd_data=0x5A one edge later; o_count=1.
- Fill and full, DEPTH=729:
  - Write 0..728 (mod 256) with i_rd_ready=0. o_count reaches 729, o_wr_ready=0, o_almost_full=1 from count 725.
  - A 730th write sets o_overflow=1 and is dropped.
  - Drain: 729 words are read out in order and o_rd_valid falls.
- Streaming: continuous write and read at 1 word/clock for 2000 words with random i_rd_ready stalls. No loss or reorder across pointer wrap; o_count is stable during simultaneous read/write.
- Frame tag, N_CH=3, DATA_W=8: write 0x030201 with i_wr_last=1 after 5 untagged words. The 6th read shows o_rd_data=0x030201 and o_rd_last=1; all others show o_rd_last=0.
- Flush and reset mid-stream:
  - With 10 words held, asserting i_flush alongside a write gives o_count=0, o_rd_valid=0, o_overflow=0; the write is ignored.
  - Repeat with an asynchronous i_rst_n pulse between edges: outputs drop immediately to reset values.
